// File: rtl/spi_dac_master.sv
// spi_dac_master
//   Multi-channel SPI master for serial DACs. A start request latches all
//   channel words, then each word is sent MSB first in its own chip-select
//   frame (channel 0 first). Optionally an LDAC strobe follows the last frame.
//
//   Parameters
//     DATA_W   bits per DAC word (8..32)
//     CH_NUM   words per transaction (1..8)
//     CLK_DIV  sys_clk_i cycles per SCL half-period (>=2)
//     SCL_IDLE scl_o level while idle; the return-to-idle edge is the sample edge
//
//   Ports
//     sys_clk_i  system clock
//     sys_rst_n  asynchronous active-low reset
//     start_i    transaction request (ignored while busy_o)
//     data_i     channel words, channel k at [k*DATA_W +: DATA_W]
//     busy_o     transaction in progress
//     done_o     one-cycle completion pulse
//     cs_o       chip select, active-low
//     scl_o      serial clock
//     mosi_o     serial data
//     ldac_o     DAC load strobe, active-low
//
//   Build option
//     SPI_DAC_LDAC_EN  when defined, an LDAC low pulse follows the last frame;
//                      when undefined, ldac_o is tied 0 and the DAC updates on
//                      the final cs_o rise.
module spi_dac_master #(
  parameter int DATA_W   = 24,
  parameter int CH_NUM   = 4,
  parameter int CLK_DIV  = 4,
  parameter bit SCL_IDLE = 1'b0
) (
  input  logic                     sys_clk_i,
  input  logic                     sys_rst_n,
  input  logic                     start_i,
  input  logic [CH_NUM*DATA_W-1:0] data_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     cs_o,
  output logic                     scl_o,
  output logic                     mosi_o,
  output logic                     ldac_o
);

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH_NUM - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP,
`ifdef SPI_DAC_LDAC_EN
    LDAC,
`endif
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [CH_NUM*DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0]        sh_q, sh_d;
  logic [DATA_W-1:0]        sh_next;
  logic                     cs_q, cs_d;
  logic                     scl_q, scl_d;
  logic                     mosi_q, mosi_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
`ifdef SPI_DAC_LDAC_EN
  logic                     ldac_q, ldac_d;
`endif

  assign sh_next = {sh_q[DATA_W-2:0], 1'b0};

  // Output values are computed for the state being entered, so every output
  // is a flop and changes on the same edge as the state register.
  // Pending channel words are kept in data_q and shifted down one word per
  // frame, so the next word is always at the bottom of the register.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    ch_d    = ch_q;
    data_d  = data_q;
    sh_d    = sh_q;
    cs_d    = cs_q;
    scl_d   = scl_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SPI_DAC_LDAC_EN
    ldac_d  = ldac_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CS_SETUP;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          scl_d   = SCL_IDLE;
          div_d   = '0;
          bit_d   = '0;
          ch_d    = '0;
          sh_d    = data_i[DATA_W-1:0];
          data_d  = data_i >> DATA_W;
          mosi_d  = data_i[DATA_W-1];
        end
      end

      CS_SETUP: begin
        if (div_q == DIV_HALF) begin
          div_d   = '0;
          scl_d   = ~SCL_IDLE;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      // One bit = 2*CLK_DIV cycles: active half, then idle half. mosi only
      // moves when the next bit's active half begins.
      SHIFT: begin
        if (div_q == DIV_HALF) begin
          scl_d = SCL_IDLE;
          div_d = div_q + 1'b1;
        end else if (div_q == DIV_FULL) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = CS_HOLD;
          end else begin
            bit_d  = bit_q + 1'b1;
            sh_d   = sh_next;
            mosi_d = sh_next[DATA_W-1];
            scl_d  = ~SCL_IDLE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      CS_HOLD: begin
        if (div_q == DIV_HALF) begin
          div_d = '0;
          cs_d  = 1'b1;
          if (ch_q == CH_LAST) begin
`ifdef SPI_DAC_LDAC_EN
            state_d = LDAC;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = GAP;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      GAP: begin
        if (div_q == DIV_HALF) begin
          div_d   = '0;
          bit_d   = '0;
          ch_d    = ch_q + 1'b1;
          cs_d    = 1'b0;
          sh_d    = data_q[DATA_W-1:0];
          data_d  = data_q >> DATA_W;
          mosi_d  = data_q[DATA_W-1];
          state_d = CS_SETUP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

`ifdef SPI_DAC_LDAC_EN
      // CLK_DIV cycles of wait after the cs_o rise, then CLK_DIV cycles low.
      LDAC: begin
        if (div_q == DIV_HALF) begin
          ldac_d = 1'b0;
          div_d  = div_q + 1'b1;
        end else if (div_q == DIV_FULL) begin
          ldac_d  = 1'b1;
          div_d   = '0;
          state_d = DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        mosi_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      sh_q    <= '0;
      cs_q    <= 1'b1;
      scl_q   <= SCL_IDLE;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SPI_DAC_LDAC_EN
      ldac_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      sh_q    <= sh_d;
      cs_q    <= cs_d;
      scl_q   <= scl_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SPI_DAC_LDAC_EN
      ldac_q  <= ldac_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign cs_o   = cs_q;
  assign scl_o  = scl_q;
  assign mosi_o = mosi_q;
`ifdef SPI_DAC_LDAC_EN
  assign ldac_o = ldac_q;
`else
  assign ldac_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_dac_master.sv
// Testbench for spi_dac_master: three configurations driven one at a time,
// with a bus monitor decoding cs_o windows, sampled bits and strobe timing.
`timescale 1ns/1ps
module tb_spi_dac_master;

`ifdef SPI_DAC_LDAC_EN
  localparam logic LDAC_RST = 1'b1;
`else
  localparam logic LDAC_RST = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  int          sel;
  logic [95:0] data_a;
  logic [23:0] data_b;
  logic [7:0]  data_c;
  logic        start_a, start_b, start_c;
  logic        cs_a, scl_a, mosi_a, ldac_a, busy_a, done_a;
  logic        cs_b, scl_b, mosi_b, ldac_b, busy_b, done_b;
  logic        cs_c, scl_c, mosi_c, ldac_c, busy_c, done_c;

  assign start_a = start & (sel == 0);
  assign start_b = start & (sel == 1);
  assign start_c = start & (sel == 2);

  spi_dac_master #(.DATA_W(24), .CH_NUM(4), .CLK_DIV(4), .SCL_IDLE(1'b0)) u_a (
    .sys_clk_i(clk), .sys_rst_n(rst_n), .start_i(start_a), .data_i(data_a),
    .busy_o(busy_a), .done_o(done_a), .cs_o(cs_a), .scl_o(scl_a),
    .mosi_o(mosi_a), .ldac_o(ldac_a));

  spi_dac_master #(.DATA_W(24), .CH_NUM(1), .CLK_DIV(4), .SCL_IDLE(1'b1)) u_b (
    .sys_clk_i(clk), .sys_rst_n(rst_n), .start_i(start_b), .data_i(data_b),
    .busy_o(busy_b), .done_o(done_b), .cs_o(cs_b), .scl_o(scl_b),
    .mosi_o(mosi_b), .ldac_o(ldac_b));

  spi_dac_master #(.DATA_W(8), .CH_NUM(1), .CLK_DIV(2), .SCL_IDLE(1'b0)) u_c (
    .sys_clk_i(clk), .sys_rst_n(rst_n), .start_i(start_c), .data_i(data_c),
    .busy_o(busy_c), .done_o(done_c), .cs_o(cs_c), .scl_o(scl_c),
    .mosi_o(mosi_c), .ldac_o(ldac_c));

  logic m_cs, m_scl, m_mosi, m_ldac, m_busy, m_done, m_idle;
  always_comb begin
    m_cs = cs_c; m_scl = scl_c; m_mosi = mosi_c; m_ldac = ldac_c;
    m_busy = busy_c; m_done = done_c; m_idle = 1'b0;
    if (sel == 0) begin
      m_cs = cs_a; m_scl = scl_a; m_mosi = mosi_a; m_ldac = ldac_a;
      m_busy = busy_a; m_done = done_a;
    end else if (sel == 1) begin
      m_cs = cs_b; m_scl = scl_b; m_mosi = mosi_b; m_ldac = ldac_b;
      m_busy = busy_b; m_done = done_b; m_idle = 1'b1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor state
  bit          mon_clr = 1'b1;
  int          cyc, nwin, n_done, n_ldac, ldac_hi, mosi_bad, scl_bad;
  int          cur_len, cur_bits, last_rise, done_cyc, ldac_fall, ldac_len;
  logic [31:0] cur_word;
  logic        done_busy;
  logic        p_cs, p_scl, p_mosi, p_ldac;
  int          win_len[8], win_bits[8], win_fall[8], gap_len[8];
  logic [31:0] win_word[8];

  initial begin
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        cyc = 0; nwin = 0; n_done = 0; n_ldac = 0; ldac_hi = 0;
        mosi_bad = 0; scl_bad = 0; cur_len = 0; cur_bits = 0; cur_word = '0;
        last_rise = 0; done_cyc = 0; ldac_fall = 0; ldac_len = 0; done_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
          win_len[i] = 0; win_bits[i] = 0; win_fall[i] = 0; gap_len[i] = 0; win_word[i] = '0;
        end
        p_cs = m_cs; p_scl = m_scl; p_mosi = m_mosi; p_ldac = m_ldac;
      end else begin
        cyc++;
        if (!m_cs) begin
          if (p_cs) begin
            cur_len = 1; cur_bits = 0; cur_word = '0;
            if (nwin > 0 && nwin <= 8) gap_len[nwin-1] = cyc - last_rise;
            if (nwin < 8) win_fall[nwin] = cyc;
          end else begin
            cur_len++;
            if (m_mosi != p_mosi && !(p_scl == m_idle && m_scl != m_idle)) mosi_bad++;
            if (p_scl != m_idle && m_scl == m_idle) begin
              cur_word = {cur_word[30:0], m_mosi};
              cur_bits++;
            end
          end
        end else begin
          if (!p_cs) begin
            if (nwin < 8) begin
              win_len[nwin] = cur_len; win_word[nwin] = cur_word; win_bits[nwin] = cur_bits;
            end
            nwin++;
            last_rise = cyc;
          end
          if (m_scl != m_idle) scl_bad++;
        end
        if (p_ldac && !m_ldac) begin ldac_fall = cyc; n_ldac++; end
        if (!p_ldac && m_ldac) ldac_len = cyc - ldac_fall;
        if (m_ldac) ldac_hi++;
        if (m_done) begin n_done++; done_cyc = cyc; done_busy = m_busy; end
        p_cs = m_cs; p_scl = m_scl; p_mosi = m_mosi; p_ldac = m_ldac;
      end
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input string tag);
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    check({tag, "_cs_before"}, m_cs, 1'b1);
    @(posedge clk); #1 start = 1'b0;
    check({tag, "_cs_latency"}, m_cs, 1'b0);
    check({tag, "_busy_latency"}, m_busy, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (n_done >= n) break;
    end
    check({tag, "_done_count"}, n_done, n);
  endtask

  task automatic check_frame(input string tag, input int nw, input int len, input int bits,
                             input int gap, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] ws[4];
    ws = '{w0, w1, w2, w3};
    check({tag, "_nwin"}, nwin, nw);
    for (int i = 0; i < nw; i++) begin
      check($sformatf("%s_len%0d", tag, i), win_len[i], len);
      check($sformatf("%s_bits%0d", tag, i), win_bits[i], bits);
      check($sformatf("%s_word%0d", tag, i), win_word[i], ws[i]);
      if (i < nw - 1) check($sformatf("%s_gap%0d", tag, i), gap_len[i], gap);
    end
    check({tag, "_mosi_stable"}, mosi_bad, 0);
    check({tag, "_scl_idle"}, scl_bad, 0);
  endtask

  task automatic check_tail_a(input string tag);
`ifdef SPI_DAC_LDAC_EN
    check({tag, "_ldac_pulses"}, n_ldac, 1);
    check({tag, "_ldac_len"}, ldac_len, 4);
    check({tag, "_ldac_delay"}, ldac_fall - last_rise, 4);
    check({tag, "_done_delay"}, done_cyc - last_rise, 9);
`else
    check({tag, "_ldac_high"}, ldac_hi, 0);
    check({tag, "_done_delay"}, done_cyc - last_rise, 1);
`endif
    check({tag, "_done_busy"}, done_busy, 1'b0);
  endtask

  localparam logic [95:0] FRAME_A = {24'h3F3004, 24'h3F2003, 24'h3F1002, 24'h3F0001};
  localparam logic [95:0] FRAME_N = {24'h0BCDEF, 24'h456789, 24'h123456, 24'hC0FFEE};

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = 0;
    data_a = '0; data_b = '0; data_c = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", cs_a, 1'b1);
    check("rst_scl", scl_a, 1'b0);
    check("rst_mosi", mosi_a, 1'b0);
    check("rst_ldac", ldac_a, LDAC_RST);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_scl_b", scl_b, 1'b1);
    check("rst_cs_c", cs_c, 1'b1);
    rst_n = 1'b1;

    // Basic 4-channel frame
    sel = 0; data_a = FRAME_A;
    clear_mon();
    pulse_start("a");
    wait_done("a", 1, 3000);
    repeat (4) @(posedge clk);
    #1;
    check_frame("a", 4, 200, 24, 4, 32'h3F0001, 32'h3F1002, 32'h3F2003, 32'h3F3004);
    check_tail_a("a");
    check("a_single_done", n_done, 1);

    // SCL idles high, single word
    sel = 1; data_b = 24'hA5A5A5;
    clear_mon();
    pulse_start("b");
    wait_done("b", 1, 1000);
    check_frame("b", 1, 200, 24, 0, 32'hA5A5A5, 0, 0, 0);

    // Smallest word, fastest divider
    sel = 2; data_c = 8'h81;
    clear_mon();
    pulse_start("c");
    wait_done("c", 1, 500);
    check_frame("c", 1, 36, 8, 0, 32'h81, 0, 0, 0);

    // start held high, data changed mid-frame
    sel = 0; data_a = FRAME_A;
    clear_mon();
    @(posedge clk); #1 start = 1'b1;
    for (int i = 0; i < 500 && nwin < 1; i++) begin @(negedge clk); #1; end
    check("bg_first_window", nwin, 1);
    data_a = FRAME_N;
    wait_done("bg", 1, 3000);
    check_frame("bg", 4, 200, 24, 4, 32'h3F0001, 32'h3F1002, 32'h3F2003, 32'h3F3004);
    repeat (3) @(negedge clk);
    #1;
    check("bg_restart_delay", win_fall[4] - done_cyc, 1);
    @(posedge clk); #1 start = 1'b0;
    wait_done("bg2", 2, 3000);
    check("bg2_nwin", nwin, 8);
    check("bg2_word0", win_word[4], 32'hC0FFEE);
    check("bg2_word3", win_word[7], 32'h0BCDEF);

    // start raised only during the DONE cycle must be ignored
    data_a = FRAME_A;
    clear_mon();
    pulse_start("dc");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
`ifdef SPI_DAC_LDAC_EN
      if (n_ldac == 1 && m_ldac) break;
`else
      if (nwin == 4) break;
`endif
    end
    check("dc_busy_in_done", m_busy, 1'b1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("dc_done_pulse", m_done, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    check("dc_no_restart", nwin, 4);
    check("dc_cs_idle", m_cs, 1'b1);

    // Reset during bit 10 of channel 1
    clear_mon();
    pulse_start("ra");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (nwin == 1 && !m_cs && cur_bits == 10 && m_scl != m_idle) break;
    end
    check("ra_reached_bit10", cur_bits, 10);
    rst_n = 1'b0;
    #1;
    check("ra_cs_async", cs_a, 1'b1);
    check("ra_scl_async", scl_a, 1'b0);
    check("ra_busy_async", busy_a, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check("ra_no_done", n_done, 0);
    check("ra_no_ldac", n_ldac, 0);
    check("ra_no_more_frames", nwin, 2);
    clear_mon();
    pulse_start("rb");
    wait_done("rb", 1, 3000);
    repeat (4) @(posedge clk);
    #1;
    check_frame("rb", 4, 200, 24, 4, 32'h3F0001, 32'h3F1002, 32'h3F2003, 32'h3F3004);
    check_tail_a("rb");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_dac_master.md
SPI_DAC_MASTER -- requirements
Module: spi_dac_master

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, meaning bits per DAC word (legal 8..32).
REQ-002 The block SHALL have parameter CH_NUM, default 4, meaning words sent per transaction (legal 1..8).
REQ-003 The block SHALL have parameter CLK_DIV, default 4, meaning sys_clk_i cycles per SCL half-period (legal >=2).
REQ-004 The block SHALL have parameter SCL_IDLE, default 0, meaning scl_o level while idle.
REQ-005 The block SHALL have port sys_clk_i, input, 1 bit: the single system clock.
REQ-006 The block SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port start_i, input, 1 bit: transaction request.
REQ-008 The block SHALL have port data_i, input, CH_NUM*DATA_W bits: channel words, where channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 The block SHALL have port busy_o, output, 1 bit: transaction in progress.
REQ-010 The block SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have ports cs_o, scl_o, mosi_o and ldac_o, each an output of 1 bit: serial DAC bus, with cs_o and ldac_o active-low.

Function
REQ-012 The FSM SHALL have states IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, LDAC and DONE; all outputs SHALL be registered.
REQ-013 In IDLE, start_i=1 SHALL latch all of data_i, set busy_o, and enter CS_SETUP on the next edge; cs_o SHALL go low 1 cycle after start_i is sampled.
REQ-014 CS_SETUP SHALL hold cs_o=0 and scl_o=SCL_IDLE for CLK_DIV cycles, with mosi_o = MSB of the current word.
REQ-015 In SHIFT, each bit SHALL last 2*CLK_DIV cycles: the first CLK_DIV cycles have scl_o=~SCL_IDLE and the second CLK_DIV cycles have scl_o=SCL_IDLE.
REQ-016 mosi_o SHALL change only at bit boundaries and SHALL be stable across the return-to-idle SCL edge, which is the DAC sample edge.
REQ-017 Bits SHALL be sent MSB first, with exactly DATA_W bits per word.
REQ-018 After the last bit, CS_HOLD SHALL keep cs_o=0 and scl_o=SCL_IDLE for CLK_DIV cycles, then drive cs_o=1.
REQ-019 If more channels remain, GAP SHALL hold cs_o=1 for CLK_DIV cycles, then return to CS_SETUP for the next channel in order 0..CH_NUM-1.
REQ-020 After the last channel, the FSM SHALL enter LDAC (if compiled in) or DONE.
REQ-021 LDAC SHALL wait CLK_DIV cycles after the cs_o rise, drive ldac_o=0 for CLK_DIV cycles, then drive ldac_o=1.
REQ-022 DONE SHALL pulse done_o for exactly 1 cycle, clear busy_o in the same cycle, and return to IDLE.
REQ-023 Per-channel cs_o low time SHALL be exactly CLK_DIV*(2*DATA_W+2) cycles.
REQ-024 start_i SHALL be ignored while busy_o=1, and data_i changes after latching SHALL NOT affect the transaction.
REQ-025 start_i asserted in the DONE cycle SHALL be ignored; it SHALL be accepted from the following IDLE cycle.
REQ-026 Bit and divider counters SHALL be sized by $clog2 of their terminal values, and no counter SHALL wrap within a transaction.

Reset
REQ-027 While sys_rst_n=0, the outputs SHALL be cs_o=1, scl_o=SCL_IDLE, mosi_o=0, ldac_o=1, busy_o=0 and done_o=0, with the FSM in IDLE.
REQ-028 Reset asserted mid-transaction SHALL abort immediately and asynchronously; no partial-frame completion, done_o pulse or LDAC pulse SHALL follow.
REQ-029 After reset release, the block SHALL accept start_i no earlier than the first clock edge.

Configuration
REQ-030 Macro SPI_DAC_LDAC_EN SHALL control the LDAC feature.
REQ-031 When SPI_DAC_LDAC_EN is defined, the LDAC state and pulse SHALL behave as in REQ-021.
REQ-032 When SPI_DAC_LDAC_EN is undefined, the LDAC state SHALL be removed, ldac_o SHALL be held constant 0 (DAC updates on the cs_o rise), and DONE SHALL follow the final CS_HOLD directly.

Verification
REQ-033 Basic frame: DATA_W=24, CH_NUM=4, CLK_DIV=4, data_i channels 0x3F0001, 0x3F1002, 0x3F2003, 0x3F3004, single start_i pulse -> 4 cs_o low windows of 200 cycles each, separated by 4-cycle gaps, decoded MSB-first words equal the inputs in order 0..3, then one ldac_o low pulse of 4 cycles followed by one done_o pulse.
REQ-034 Mode: SCL_IDLE=1, single word 0xA5A5A5 -> scl_o idles high, 24 falling-then-rising bit periods are produced, and mosi_o sampled on each rising edge yields 0xA5A5A5.
REQ-035 Busy guard: start_i held high throughout and data_i changed mid-frame -> exactly one transaction is sent carrying the originally latched data, and a second transaction begins only after done_o.
REQ-036 Reset abort: sys_rst_n pulled low during bit 10 of channel 1 -> cs_o=1, scl_o=SCL_IDLE and busy_o=0 within the same cycle, with no done_o or ldac_o pulse; a new start_i then produces a full correct frame.
REQ-037 Macro off: build without SPI_DAC_LDAC_EN and run the REQ-033 stimulus -> ldac_o is constant 0 and done_o fires 1 cycle after the last cs_o rise.
REQ-038 Edge parameters: DATA_W=8, CH_NUM=1, CLK_DIV=2, data 0x81 -> cs_o low for 36 cycles and the decoded bit pattern is 1000_0001.
